// File: rtl/spi_master.sv
// SPI master: takes a 10-bit command from the host, shifts it out MSB first on MOSI,
// and for read-data commands captures the 8-bit MISO response after a turnaround gap.
module spi_master #(
  parameter int unsigned TURNAROUND = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       busy
);

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TA_LAST = CNT_W'(TURNAROUND - 1);
  localparam logic [1:0]       OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT_TX,
    WAIT,
    SHIFT_RX,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0]    tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                rd_op_q, rd_op_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  assign cmd_ready = (state_q == IDLE) && !rst;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_op_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_op_q    <= rd_op_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Next state; output registers are loaded with the values of the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_op_d    = rd_op_q;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = START;
          tx_d    = cmd_data;
          rd_op_d = (cmd_data[9:8] == OP_RD_DATA);
          ss_n_d  = 1'b0;
          mosi_d  = cmd_data[9];
        end
      end

      // START and the first SHIFT_TX cycle both present cmd[9]
      START: begin
        state_d = SHIFT_TX;
        cnt_d   = '0;
        ss_n_d  = 1'b0;
        mosi_d  = tx_q[9];
      end

      SHIFT_TX: begin
        if (cnt_q == TX_LAST) begin
          cnt_d = '0;
          if (rd_op_q) begin
            state_d = WAIT;
            ss_n_d  = 1'b0;
          end else begin
            state_d = STOP;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          tx_d   = {tx_q[CMD_W-2:0], 1'b0};
          ss_n_d = 1'b0;
          mosi_d = tx_q[CMD_W-2];
        end
      end

      WAIT: begin
        ss_n_d = 1'b0;
        if (cnt_q == TA_LAST) begin
          state_d = SHIFT_RX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The edge ending the last RX cycle samples the final bit straight into rd_data
      SHIFT_RX: begin
        rx_d = {rx_q[DATA_W-2:0], MISO};
        if (cnt_q == RX_LAST) begin
          state_d    = STOP;
          cnt_d      = '0;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = {rx_q[DATA_W-2:0], MISO};
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          ss_n_d = 1'b0;
        end
      end

      STOP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (TURNAROUND=2 and 1) sharing clock,
// reset, cmd_data and MISO; the selected instance gets cmd_valid and is observed.
module tb_spi_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       MISO;
  logic       sel;

  logic       ready0, ss0, mosi0, rdv0, done0, busy0;
  logic [7:0] rdd0;
  logic       ready1, ss1, mosi1, rdv1, done1, busy1;
  logic [7:0] rdd1;

  int n_tests;
  int n_fail;
  logic [7:0] exp_rd [2];

  spi_master #(.TURNAROUND(2)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(ready0),
    .cmd_data(cmd_data), .SS_n(ss0), .MOSI(mosi0), .MISO(MISO),
    .rd_data(rdd0), .rd_valid(rdv0), .done(done0), .busy(busy0)
  );

  spi_master #(.TURNAROUND(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(ready1),
    .cmd_data(cmd_data), .SS_n(ss1), .MOSI(mosi1), .MISO(MISO),
    .rd_data(rdd1), .rd_valid(rdv1), .done(done1), .busy(busy1)
  );

  wire       o_ready = sel ? ready1 : ready0;
  wire       o_ss_n  = sel ? ss1    : ss0;
  wire       o_mosi  = sel ? mosi1  : mosi0;
  wire       o_rdv   = sel ? rdv1   : rdv0;
  wire       o_done  = sel ? done1  : done0;
  wire       o_busy  = sel ? busy1  : busy0;
  wire [7:0] o_rdd   = sel ? rdd1   : rdd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of cycle T+1; checks every cycle through STOP, returns in cycle after STOP.
  task automatic observe(input logic [9:0] cmd, input logic [7:0] rbyte, input int ta,
                         input int pulse_at, input string nm);
    bit rd;
    int total;
    int k;
    logic exp_mosi;
    rd    = (cmd[9:8] == 2'b11);
    total = rd ? 20 + ta : 12;
    for (int c = 1; c <= total; c++) begin
      if (rd && c >= 12 + ta && c <= 19 + ta) begin
        k    = c - 12 - ta;
        MISO = rbyte[7 - k];
      end else begin
        MISO = 1'b1;
      end
      if (pulse_at > 0) begin
        cmd_valid = (c == pulse_at);
        cmd_data  = 10'h0AA;
      end
      if (c == 1)                exp_mosi = cmd[9];
      else if (c >= 2 && c <= 11) exp_mosi = cmd[11 - c];
      else                        exp_mosi = 1'b0;
      if (rd && c == total) exp_rd[sel] = rbyte;
      check($sformatf("%s ss_n c%0d", nm, c), 32'(o_ss_n), 32'(c < total ? 1'b0 : 1'b1));
      check($sformatf("%s mosi c%0d", nm, c), 32'(o_mosi), 32'(exp_mosi));
      check($sformatf("%s done c%0d", nm, c), 32'(o_done), 32'(c == total));
      check($sformatf("%s rd_valid c%0d", nm, c), 32'(o_rdv), 32'(rd && c == total));
      check($sformatf("%s rd_data c%0d", nm, c), 32'(o_rdd), 32'(exp_rd[sel]));
      check($sformatf("%s busy c%0d", nm, c), 32'(o_busy), 32'd1);
      check($sformatf("%s ready c%0d", nm, c), 32'(o_ready), 32'd0);
      tick();
    end
    if (pulse_at > 0) cmd_valid = 1'b0;
    MISO = 1'b0;
    check($sformatf("%s idle ready", nm), 32'(o_ready), 32'd1);
    check($sformatf("%s idle ss_n", nm), 32'(o_ss_n), 32'd1);
    check($sformatf("%s idle busy", nm), 32'(o_busy), 32'd0);
    check($sformatf("%s idle done", nm), 32'(o_done), 32'd0);
    check($sformatf("%s idle rd_data", nm), 32'(o_rdd), 32'(exp_rd[sel]));
  endtask

  task automatic send(input bit s, input logic [9:0] cmd, input logic [7:0] rbyte,
                      input int ta, input int pulse_at, input string nm);
    sel       = s;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    check({nm, " hs ready"}, 32'(o_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = ~cmd;
    observe(cmd, rbyte, ta, pulse_at, nm);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    sel       = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    MISO      = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      check($sformatf("rst%0d ss_n", s), 32'(o_ss_n), 32'd1);
      check($sformatf("rst%0d mosi", s), 32'(o_mosi), 32'd0);
      check($sformatf("rst%0d rd_data", s), 32'(o_rdd), 32'd0);
      check($sformatf("rst%0d rd_valid", s), 32'(o_rdv), 32'd0);
      check($sformatf("rst%0d done", s), 32'(o_done), 32'd0);
      check($sformatf("rst%0d busy", s), 32'(o_busy), 32'd0);
      check($sformatf("rst%0d ready", s), 32'(o_ready), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    #1;
    check("post-rst ready", 32'(o_ready), 32'd1);
    tick();

    send(1'b0, 10'b00_1010_0101, 8'h00, 2, 0, "wr_addr");
    tick();
    send(1'b0, 10'b11_0000_0000, 8'h3C, 2, 0, "rd_3c");
    tick();

    // Back-to-back with cmd_valid held; cmd_data changes while busy must not matter
    sel       = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 10'h1FF;
    check("b2b hs1 ready", 32'(o_ready), 32'd1);
    tick();
    cmd_data = 10'h212;
    observe(10'h1FF, 8'h00, 2, 0, "b2b1");
    tick();
    cmd_valid = 1'b0;
    observe(10'h212, 8'h00, 2, 0, "b2b2");
    tick();

    // cmd_valid pulse inside SHIFT_RX (cycles T+14..T+21) is dropped
    send(1'b0, 10'h3C3, 8'h81, 2, 16, "busydrop");
    tick();
    check("busydrop no hs ss_n", 32'(o_ss_n), 32'd1);
    check("busydrop no hs busy", 32'(o_busy), 32'd0);

    // Reset mid-SHIFT_TX; rd_data holds 0x81 beforehand and must clear
    cmd_valid = 1'b1;
    cmd_data  = 10'h3FF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre-rst ss_n low", 32'(o_ss_n), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst ss_n %0d", i), 32'(o_ss_n), 32'd1);
      check($sformatf("midrst mosi %0d", i), 32'(o_mosi), 32'd0);
      check($sformatf("midrst busy %0d", i), 32'(o_busy), 32'd0);
      check($sformatf("midrst rd_data %0d", i), 32'(o_rdd), 32'd0);
      check($sformatf("midrst done %0d", i), 32'(o_done), 32'd0);
      check($sformatf("midrst rd_valid %0d", i), 32'(o_rdv), 32'd0);
    end
    rst       = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    #1;
    check("midrst ready after", 32'(o_ready), 32'd1);
    tick();
    check("midrst no done", 32'(o_done), 32'd0);

    send(1'b1, 10'b11_0101_0101, 8'hA5, 1, 0, "ta1_rd_a5");
    tick();
    send(1'b1, 10'b01_1100_0011, 8'h00, 1, 0, "ta1_wr_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
